// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame master.
package spi_pkg;

  // Width of the SCLK half-period divider counter (DIV up to 255).
  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timebase: counts DIV clk cycles per half-period while enabled and
// emits single-cycle strobes in the last cycle of each half. `lead` ends an
// idle half (sclk about to go active), `trail` ends an active half.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic lead,
  output logic trail
);

  logic [DIV_W-1:0] cnt;
  logic             phase;  // 0: idle half, 1: active half
  logic             tick;

  assign tick  = en && (cnt == DIV_W'(DIV - 1));
  assign lead  = tick && !phase;
  assign trail = tick && phase;

  // Half-period counter; restarts in the idle phase whenever disabled so
  // every frame begins with a full idle half (the SETUP window).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_main.sv
// SPI frame master (CPHA=0): sends up to WIDTH bits from a left-aligned tx
// word and returns the received bits right-aligned in rx.
// Optional build macro SPI_FRAME_LSB_FIRST_EN switches transmit order to
// LSB first (tx bit WIDTH-len upward); default is MSB first.
module spi_frame_main
  import spi_pkg::*;
#(
  parameter  int WIDTH = 258,
  parameter  int DIV   = 1,
  parameter  bit CPOL  = 1'b0,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] tx,
  output logic [WIDTH-1:0] rx,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  state_t           state;
  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] tx_ld;
  logic [WIDTH-1:0] tx_nxt;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] rx_nxt;
  logic             lead;
  logic             trail;
  logic             last_bit;

  // Oversized lengths run a full-width frame.
  assign len_c = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

  // The wire bit is always the end of tx_sr that the shift moves toward.
`ifdef SPI_FRAME_LSB_FIRST_EN
  assign tx_ld  = tx >> (LEN_W'(WIDTH) - len_c);
  assign tx_nxt = tx_sr >> 1;
  assign mosi   = tx_sr[0];
`else
  assign tx_ld  = tx;
  assign tx_nxt = tx_sr << 1;
  assign mosi   = tx_sr[WIDTH-1];
`endif

  // Received bits enter at the bottom, so the first bit ends at rx[len-1].
  assign rx_nxt   = {rx_sh[WIDTH-2:0], miso};
  assign last_bit = (bit_cnt == len_q - LEN_W'(1));

  spi_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (busy),
    .lead  (lead),
    .trail (trail)
  );

  // Frame sequencer. The last bit's idle half doubles as HOLD, so the frame
  // spans SETUP + 2*len halves + HOLD minus one overlap = DIV*(2*len+1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cs_n    <= 1'b1;
      sclk    <= CPOL;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx      <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sh   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q   <= len_c;
            bit_cnt <= '0;
            rx_sh   <= '0;
            if (len_c == '0) begin
              // Empty frame: report completion without touching the bus.
              state <= S_DONE;
              done  <= 1'b1;
              rx    <= '0;
            end else begin
              state <= S_SETUP;
              cs_n  <= 1'b0;
              busy  <= 1'b1;
              tx_sr <= tx_ld;
            end
          end
        end
        S_SETUP: begin
          if (lead) begin
            state <= S_SHIFT;
            sclk  <= ~CPOL;
            rx_sh <= rx_nxt;
          end
        end
        S_SHIFT: begin
          if (lead) begin
            sclk  <= ~CPOL;
            rx_sh <= rx_nxt;
          end else if (trail) begin
            sclk <= CPOL;
            if (last_bit) begin
              state <= S_HOLD;
            end else begin
              bit_cnt <= bit_cnt + LEN_W'(1);
              tx_sr   <= tx_nxt;
            end
          end
        end
        S_HOLD: begin
          if (lead) begin
            state <= S_DONE;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            rx    <= rx_sh;
            tx_sr <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_frame_main.md
SPI_FRAME_MAIN -- requirements
Module: spi_frame_main

Interface
REQ-001 SHALL have parameter WIDTH, default 258, maximum frame length in bits and width of tx/rx.
REQ-002 SHALL have parameter DIV, default 1, SCLK half-period in clk cycles; legal values are 1 to 255.
REQ-003 SHALL have parameter CPOL, default 0, SCLK idle level; data is always sampled on the leading edge (CPHA=0).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic uses its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a frame.
REQ-007 SHALL have port len, input, LEN_W = clog2(WIDTH+1), number of bits in the frame, sampled together with start.
REQ-008 SHALL have port tx, input, WIDTH, transmit data, left-aligned; tx[WIDTH-1] is sent first.
REQ-009 SHALL have port rx, output, WIDTH, received data, right-aligned in rx[len-1:0], with the upper bits zero.
REQ-010 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at the end of a frame.
REQ-012 SHALL have ports cs_n (output, 1), sclk (output, 1), mosi (output, 1) and miso (input, 1), the serial bus.

Function
REQ-013 SHALL implement the states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-014 SHALL capture tx and len, and set busy, when start=1 in IDLE (cycle T0); start in any other state SHALL be ignored.
REQ-015 SHALL enter SETUP at T0+1 for DIV cycles, with cs_n=0, sclk=CPOL and mosi holding the first bit.
REQ-016 SHALL drive each bit in SHIFT as DIV cycles with sclk active followed by DIV cycles with sclk idle.
REQ-017 SHALL sample miso on the clk edge where sclk becomes active, and shift mosi to the next bit where sclk returns idle.
REQ-018 SHALL hold cs_n=0 and sclk idle for DIV cycles in HOLD after the last bit.
REQ-019 SHALL, in DONE at cycle T0+1+DIV*(2*len+1): set cs_n=1, pulse done, update rx and clear busy; the next cycle is IDLE.
REQ-020 SHALL keep rx stable between done pulses.
REQ-021 SHALL accept a new start in the cycle after done.
REQ-022 SHALL, for len=0, skip the bus entirely: no cs_n assertion, done at T0+1, rx=0.
REQ-023 SHALL clamp len>WIDTH to WIDTH.
REQ-024 SHALL size the bit counter to LEN_W and the divider counter to 8 bits, with no wrap-around inside a frame.

Reset
REQ-025 SHALL, while rst=1 (including mid-frame), immediately force IDLE with cs_n=1, sclk=CPOL, mosi=0, busy=0, done=0 and rx=0.
REQ-026 SHALL NOT generate a partial done or any sclk edge on reset release.

Configuration
REQ-027 SHALL, with SPI_FRAME_LSB_FIRST_EN defined, transmit tx from bit WIDTH-len upward (LSB first) and fill rx from rx[len-1] downward.
REQ-028 SHALL, without SPI_FRAME_LSB_FIRST_EN, use MSB-first ordering as in REQ-008 and REQ-009.

Structure
REQ-029 SHALL place the state enum and the divider-width constant in package spi_pkg.
REQ-030 SHALL use one sub-module, spi_clk_gen, which divides by DIV and emits single-cycle lead/trail strobes.

Verification
REQ-031 SHALL test MSB-first loopback (miso tied to mosi) with DIV=1, len=130 and tx = {2'b00, 128'h000102030405060708090a0b0c0d0e0f} left-aligned -> rx[129:0] equals the sent value; done at T0+262.
REQ-032 SHALL test a 258-bit frame with tx = {2'b10, 256'h00..1f} -> exactly 258 sclk rising edges and cs_n low for 517 cycles.
REQ-033 SHALL test len=8 with DIV=3, miso driven with 8'hA5 -> rx=8'hA5, sclk period 6 clk cycles, done at T0+52.
REQ-034 SHALL test a second start during busy -> it is ignored, and exactly one done is produced.
REQ-035 SHALL test rst asserted during the 40th bit -> outputs reach their reset values in the same cycle; after release, a new frame completes correctly.
REQ-036 SHALL test len=0 and, separately, CPOL=1 -> done at T0+1 with no cs_n activity; for CPOL=1, sclk idles high and the loopback data is unchanged.
